// File: rtl/seg_pkg.sv
// Shared constants for 7-segment readback: the active-low encoding table, blank code,
// scan FSM states and the largest supported digit count.
package seg_pkg;

    localparam int MAX_DIGITS = 8;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Index is the hex value; bit6=g .. bit0=a, active-low.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } scan_state_t;

endpackage

// File: rtl/seg_pattern_lookup.sv
// Purpose: map an active-low 7-segment pattern to {hit, blank, nibble} by exact table match.
// Latency: purely combinational.
// Backpressure: none; evaluated continuously.
module seg_pattern_lookup
    import seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       hit,
    output logic       blank,
    output logic [3:0] nibble
);

    always_comb begin
        hit    = 1'b0;
        nibble = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == SEG_TABLE[i]) begin
                hit    = 1'b1;
                nibble = 4'(i);
            end
        end
    end

    assign blank = (pattern == SEG_BLANK);

endmodule

// File: rtl/seg_scan_decoder.sv
// Purpose: recover per-digit hex values from a scanned active-low 7-seg bus; SEG_SCAN_DP_EN adds decimal point.
// Latency: capture at edge E+STABLE_CYCLES for a sample first registered at edge E.
// Backpressure: none; passive monitor, unstable or non-one-hot samples are simply not captured.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              a_seg,
    input  logic [NUM_DIGITS-1:0]   an_sel,
`ifdef SEG_SCAN_DP_EN
    input  logic                    a_dp,
    output logic [NUM_DIGITS-1:0]   dp_out,
`endif
    input  logic                    clr_err,
    output logic [4*NUM_DIGITS-1:0] cif_hexa_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    dig_upd,
    output logic                    err_pattern
);

    if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
        $error("seg_scan_decoder: NUM_DIGITS out of range");
    end
    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("seg_scan_decoder: STABLE_CYCLES must be at least 2");
    end

    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

`ifdef SEG_SCAN_DP_EN
    localparam int SW = NUM_DIGITS + 8;
    logic [SW-1:0] nxt;
    assign nxt = {an_sel, a_dp, a_seg};
`else
    localparam int SW = NUM_DIGITS + 7;
    logic [SW-1:0] nxt;
    assign nxt = {an_sel, a_seg};
`endif

    logic [SW-1:0]         smp;
    logic [CW-1:0]         cnt;
    scan_state_t           state;
    logic [NUM_DIGITS-1:0] smp_an;
    logic [6:0]            smp_seg;
    logic                  changed;
    logic                  nxt_onehot;
    logic                  lk_hit;
    logic                  lk_blank;
    logic [3:0]            lk_nib;

    function automatic logic onehot_low(input logic [NUM_DIGITS-1:0] an);
        logic [NUM_DIGITS-1:0] lo;
        lo = ~an;
        return (lo != '0) && ((lo & (lo - NUM_DIGITS'(1))) == '0);
    endfunction

    assign smp_an     = smp[SW-1 -: NUM_DIGITS];
    assign smp_seg    = smp[6:0];
    assign changed    = (nxt != smp);
    assign nxt_onehot = onehot_low(nxt[SW-1 -: NUM_DIGITS]);

    // Decode the registered sample; at capture time it equals the live input anyway.
    seg_pattern_lookup u_lookup (
        .pattern (smp_seg),
        .hit     (lk_hit),
        .blank   (lk_blank),
        .nibble  (lk_nib)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp          <= '1;
            cnt          <= '0;
            state        <= IDLE;
            cif_hexa_out <= '0;
            digit_valid  <= '0;
            dig_upd      <= 1'b0;
            err_pattern  <= 1'b0;
`ifdef SEG_SCAN_DP_EN
            dp_out       <= '0;
`endif
        end else begin
            smp     <= nxt;
            dig_upd <= 1'b0;
            if (clr_err) begin
                err_pattern <= 1'b0;
            end

            if (changed) begin
                cnt   <= '0;
                state <= nxt_onehot ? SETTLE : IDLE;
            end else begin
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + CW'(1);
                end
                if (state == SETTLE && cnt == CNT_MAX) begin
                    state <= HOLD;
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (!smp_an[i]) begin
                            digit_valid[i] <= lk_hit;
                            if (lk_hit) begin
                                cif_hexa_out[4*i +: 4] <= lk_nib;
                            end
`ifdef SEG_SCAN_DP_EN
                            if (lk_hit || lk_blank) begin
                                dp_out[i] <= ~smp[7];
                            end
`endif
                        end
                    end
                    dig_upd <= lk_hit;
                    // Placed after the clear so a coincident error keeps the flag set.
                    if (!lk_hit && !lk_blank) begin
                        err_pattern <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scenarios plus a scoreboard of expected captures
// that a negedge monitor checks on every dig_upd pulse.
module tb_seg_scan_decoder;

    localparam int ND = 4;
    localparam int SC = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [6:0]    a_seg;
    logic [ND-1:0] an_sel;
    logic          clr_err;
    logic [4*ND-1:0] cif_hexa_out;
    logic [ND-1:0] digit_valid;
    logic          dig_upd;
    logic          err_pattern;
`ifdef SEG_SCAN_DP_EN
    logic [ND-1:0] dp_out;
`endif

    typedef struct {
        int         d;
        logic [3:0] nib;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [6:0] tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    always #5 clk = ~clk;

    seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a_seg        (a_seg),
        .an_sel       (an_sel),
`ifdef SEG_SCAN_DP_EN
        .a_dp         (1'b1),
        .dp_out       (dp_out),
`endif
        .clr_err      (clr_err),
        .cif_hexa_out (cif_hexa_out),
        .digit_valid  (digit_valid),
        .dig_upd      (dig_upd),
        .err_pattern  (err_pattern)
    );

    // Scoreboard monitor: every update pulse must match the oldest expected capture.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && dig_upd === 1'b1) begin
            exp_t e;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_upd: dig_upd=1 cif=%h valid=%b, required no update", cif_hexa_out, digit_valid);
            end else begin
                e = sb.pop_front();
                if (cif_hexa_out[4*e.d +: 4] !== e.nib || digit_valid[e.d] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL sb_capture: digit %0d nib=%h valid=%b, required nib=%h valid bit 1",
                             e.d, cif_hexa_out[4*e.d +: 4], digit_valid, e.nib);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; an_sel = 4'b1111; a_seg = 7'b1111111; clr_err = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++;
        if (cif_hexa_out !== '0 || digit_valid !== '0 || dig_upd !== 1'b0 || err_pattern !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: cif=%h valid=%b upd=%b err=%b, required all zero",
                     cif_hexa_out, digit_valid, dig_upd, err_pattern);
        end
    endtask

    task automatic test_capture_latency();
        an_sel = 4'b1110; a_seg = 7'b0110000;
        sb.push_back('{0, 4'h3});
        repeat (SC) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (dig_upd !== 1'b0 || digit_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL latency_early: upd=%b valid=%b one edge before capture, required 0/0000", dig_upd, digit_valid);
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (dig_upd !== 1'b1 || cif_hexa_out[3:0] !== 4'h3 || digit_valid !== 4'b0001) begin
            n_fail++;
            $display("FAIL latency_capture: upd=%b nib=%h valid=%b, required 1/3/0001", dig_upd, cif_hexa_out[3:0], digit_valid);
        end
        @(negedge clk);
        n_checks++;
        if (dig_upd !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pulse: upd=%b after capture, required 0", dig_upd);
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_glitch_reject();
        an_sel = 4'b1101; a_seg = 7'b0001000;
        repeat (5) @(negedge clk);
        a_seg = 7'b0000011;
        sb.push_back('{1, 4'hB});
        repeat (SC) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (digit_valid[1] !== 1'b0 || dig_upd !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_early: valid=%b upd=%b, required digit1 not yet valid", digit_valid, dig_upd);
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (cif_hexa_out[7:4] !== 4'hB || digit_valid !== 4'b0011) begin
            n_fail++;
            $display("FAIL glitch_capture: nib1=%h valid=%b, required B/0011", cif_hexa_out[7:4], digit_valid);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_blank();
        an_sel = 4'b1110; a_seg = 7'b1111111;
        repeat (12) @(negedge clk);
        n_checks++;
        if (digit_valid !== 4'b0010 || cif_hexa_out[3:0] !== 4'h3 || cif_hexa_out[7:4] !== 4'hB || err_pattern !== 1'b0) begin
            n_fail++;
            $display("FAIL blank: valid=%b cif=%h err=%b, required valid 0010 cif[7:0]=b3 err 0",
                     digit_valid, cif_hexa_out, err_pattern);
        end
    endtask

    task automatic test_error();
        an_sel = 4'b1011; a_seg = 7'b1010101;
        repeat (SC + 1) @(negedge clk);
        n_checks++;
        if (err_pattern !== 1'b1 || digit_valid !== 4'b0010) begin
            n_fail++;
            $display("FAIL err_set: err=%b valid=%b, required 1/0010", err_pattern, digit_valid);
        end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        n_checks++;
        if (err_pattern !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: err=%b after clr_err, required 0", err_pattern);
        end
        an_sel = 4'b0111; a_seg = 7'b1010101;
        repeat (SC) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (err_pattern !== 1'b0) begin
            n_fail++;
            $display("FAIL err_early: err=%b before capture edge, required 0", err_pattern);
        end
        clr_err = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr_err = 1'b0;
        n_checks++;
        if (err_pattern !== 1'b1 || digit_valid !== 4'b0010) begin
            n_fail++;
            $display("FAIL err_set_wins: err=%b valid=%b, required 1/0010", err_pattern, digit_valid);
        end
    endtask

    task automatic test_multi_low();
        an_sel = 4'b1100; a_seg = 7'b0000000;
        repeat (20) @(negedge clk);
        n_checks++;
        if (digit_valid !== 4'b0010 || cif_hexa_out[7:0] !== 8'hB3 || err_pattern !== 1'b1) begin
            n_fail++;
            $display("FAIL multi_low: valid=%b cif=%h err=%b, required 0010/..b3/1", digit_valid, cif_hexa_out, err_pattern);
        end
    endtask

    task automatic test_reset_mid_settle();
        an_sel = 4'b1110; a_seg = 7'b0000000;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (cif_hexa_out !== '0 || digit_valid !== '0 || dig_upd !== 1'b0 || err_pattern !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: cif=%h valid=%b upd=%b err=%b, required all zero",
                     cif_hexa_out, digit_valid, dig_upd, err_pattern);
        end
        @(negedge clk);
        sb.push_back('{0, 4'h8});
        rst_n = 1'b1;
        repeat (SC) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (digit_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_discard: valid=%b before fresh count ends, required 0000", digit_valid);
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (digit_valid !== 4'b0001 || cif_hexa_out !== 16'h0008) begin
            n_fail++;
            $display("FAIL reset_recapture: valid=%b cif=%h, required 0001/0008", digit_valid, cif_hexa_out);
        end
        an_sel = 4'b1111; a_seg = 7'b1111111;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [ND-1:0]   exp_valid = 4'b0001;
        logic [4*ND-1:0] exp_cif   = 16'h0008;
        for (int k = 0; k < 8; k++) begin
            int d   = $urandom_range(0, ND - 1);
            int nib = $urandom_range(0, 15);
            an_sel = ~(4'b0001 << d);
            a_seg  = tab[nib];
            sb.push_back('{d, 4'(nib)});
            exp_valid[d] = 1'b1;
            exp_cif[4*d +: 4] = 4'(nib);
            repeat (SC + 1 + $urandom_range(0, 3)) @(negedge clk);
            an_sel = 4'b1111; a_seg = 7'b1111111;
            @(negedge clk);
        end
        n_checks++;
        if (digit_valid !== exp_valid || cif_hexa_out !== exp_cif) begin
            n_fail++;
            $display("FAIL back_to_back: valid=%b cif=%h, required %b/%h", digit_valid, cif_hexa_out, exp_valid, exp_cif);
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d captures outstanding, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_capture_latency();
        test_glitch_reject();
        test_blank();
        test_error();
        test_multi_low();
        test_reset_mid_settle();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
